triangle_wave: RTL and testbench



---
 rtl/triangle_wave_pkg.sv | 8 +
 rtl/triangle_wave_step_prescaler.sv | 33 +++
 rtl/triangle_wave.sv | 102 ++++++++++
 tb/tb_triangle_wave.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/triangle_wave_pkg.sv
// Shared constants for the triangle waveform generator.
package triangle_wave_pkg;

  // Direction flop encoding; the reset direction is rising.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : triangle_wave_pkg

// File: rtl/triangle_wave_step_prescaler.sv
// Divides enabled cycles down to waveform steps: one step every DIV enabled
// cycles. Dropping enable restarts the count, so a resumed run always waits a
// full DIV enabled cycles before its next step. With DIV = 1 the counter never
// leaves 0 and step simply follows enable.
module step_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // A step fires on the enabled cycle where the count sits at its terminal value.
  assign step = enable && (cnt == TERM);

  // Count enabled cycles 0..DIV-1, wrapping on a step and clearing while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : step_prescaler

// File: rtl/triangle_wave.sv
// Digital triangle waveform between two live bounds. Out-of-range values are
// pulled straight onto the nearest bound at the next step, so a bound change
// never produces a value outside the new range.
//
// dir state | meaning
// DIR_UP    | sweeping towards high_in (also the reset / degenerate-range state)
// DIR_DOWN  | sweeping towards low_in
module triangle_wave
  import triangle_wave_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] low_in,
  input  logic [WIDTH-1:0] high_in,
  output logic [WIDTH-1:0] mod_out,
  output logic             dir_out,
  output logic             peak_out,
  output logic             trough_out
);

  logic             step;
  logic [WIDTH-1:0] v_inc;
  logic [WIDTH-1:0] v_dec;
  logic [WIDTH-1:0] v_next;
  logic             dir_next;
  logic             peak_next;
  logic             trough_next;

  step_prescaler #(
    .DIV (DIV)
  ) u_step_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .step   (step)
  );

  // Increment/decrement are only selected when the value is strictly inside
  // the range, so neither can wrap.
  assign v_inc = mod_out + 1'b1;
  assign v_dec = mod_out - 1'b1;

  // Next value, direction and pulses for a step, in bound-priority order.
  always_comb begin
    v_next      = mod_out;
    dir_next    = dir_out;
    peak_next   = 1'b0;
    trough_next = 1'b0;
    if (low_in >= high_in) begin
      // Degenerate range: park on low_in, no pulses.
      v_next   = low_in;
      dir_next = DIR_UP;
    end else if (mod_out < low_in) begin
      v_next      = low_in;
      dir_next    = DIR_UP;
      trough_next = 1'b1;
    end else if (mod_out > high_in) begin
      v_next    = high_in;
      dir_next  = DIR_DOWN;
      peak_next = 1'b1;
    end else if (dir_out == DIR_UP) begin
      if (mod_out == high_in) begin
        v_next   = v_dec;
        dir_next = DIR_DOWN;
      end else begin
        v_next    = v_inc;
        peak_next = (v_inc == high_in);
      end
    end else begin
      if (mod_out == low_in) begin
        v_next   = v_inc;
        dir_next = DIR_UP;
      end else begin
        v_next      = v_dec;
        trough_next = (v_dec == low_in);
      end
    end
  end

  // Waveform registers advance only on steps; pulses are cleared otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      mod_out    <= '0;
      dir_out    <= DIR_UP;
      peak_out   <= 1'b0;
      trough_out <= 1'b0;
    end else if (step) begin
      mod_out    <= v_next;
      dir_out    <= dir_next;
      peak_out   <= peak_next;
      trough_out <= trough_next;
    end else begin
      peak_out   <= 1'b0;
      trough_out <= 1'b0;
    end
  end

endmodule : triangle_wave

// File: tb/tb_triangle_wave.sv
// Directed bench for triangle_wave: one instance with DIV = 1 and one with DIV = 3.
module tb_triangle_wave;

  logic       clk;
  logic       reset_a, enable_a;
  logic [3:0] low_a, high_a, mod_a;
  logic       dir_a, peak_a, trough_a;
  logic       reset_b, enable_b;
  logic [3:0] low_b, high_b, mod_b;
  logic       dir_b, peak_b, trough_b;

  int compared   = 0;
  int mismatched = 0;

  triangle_wave #(.WIDTH(4), .DIV(1)) dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .enable     (enable_a),
    .low_in     (low_a),
    .high_in    (high_a),
    .mod_out    (mod_a),
    .dir_out    (dir_a),
    .peak_out   (peak_a),
    .trough_out (trough_a)
  );

  triangle_wave #(.WIDTH(4), .DIV(3)) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .enable     (enable_b),
    .low_in     (low_b),
    .high_in    (high_b),
    .mod_out    (mod_b),
    .dir_out    (dir_b),
    .peak_out   (peak_b),
    .trough_out (trough_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int e;
    reset_a = 1'b1; enable_a = 1'b1; low_a = 4'd0; high_a = 4'd13;
    reset_b = 1'b1; enable_b = 1'b0; low_b = 4'd0; high_b = 4'd3;

    // Reset dominates enable.
    tick();
    check("a_rst_mod", mod_a, 0);
    check("a_rst_dir", dir_a, 1);
    check("a_rst_peak", peak_a, 0);
    check("a_rst_trough", trough_a, 0);

    // Full sweep 0..13: 1..13, 12..0, then 1 again.
    reset_a = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      tick();
      e = (i <= 13) ? i : ((i <= 26) ? 26 - i : i - 26);
      check($sformatf("a_sweep_mod_%0d", i), mod_a, e);
      check($sformatf("a_sweep_dir_%0d", i), dir_a, (i <= 13 || i >= 27) ? 1 : 0);
      check($sformatf("a_sweep_peak_%0d", i), peak_a, (i == 13) ? 1 : 0);
      check($sformatf("a_sweep_trough_%0d", i), trough_a, (i == 26) ? 1 : 0);
    end

    // Up to 13 again, then falling to 2.
    repeat (23) tick();
    check("a_fall2_mod", mod_a, 2);
    check("a_fall2_dir", dir_a, 0);

    // Raise low bound below the current value.
    low_a = 4'd5;
    tick();
    check("a_lowjump_mod", mod_a, 5);
    check("a_lowjump_dir", dir_a, 1);
    check("a_lowjump_trough", trough_a, 1);

    repeat (7) tick();
    check("a_at12_mod", mod_a, 12);
    check("a_at12_dir", dir_a, 1);

    // Drop high bound below the current value.
    high_a = 4'd10;
    tick();
    check("a_highjump_mod", mod_a, 10);
    check("a_highjump_dir", dir_a, 0);
    check("a_highjump_peak", peak_a, 1);

    for (int j = 1; j <= 5; j++) begin
      tick();
      check($sformatf("a_fall10_mod_%0d", j), mod_a, 10 - j);
      check($sformatf("a_fall10_trough_%0d", j), trough_a, (j == 5) ? 1 : 0);
    end

    high_a = 4'd13;
    tick();
    check("a_restore_mod", mod_a, 6);
    check("a_restore_dir", dir_a, 1);
    for (int j = 0; j < 30; j++) begin
      tick();
      check($sformatf("a_inrange_%0d", j), (mod_a >= 4'd5 && mod_a <= 4'd13), 1);
    end

    // Reset mid-operation, then climb 5,6,7 and freeze.
    reset_a = 1'b1;
    tick();
    check("a_midrst_mod", mod_a, 0);
    check("a_midrst_dir", dir_a, 1);
    reset_a = 1'b0;
    tick();
    check("a_rule2_mod", mod_a, 5);
    check("a_rule2_trough", trough_a, 1);
    repeat (2) tick();
    check("a_at7_mod", mod_a, 7);
    enable_a = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      check($sformatf("a_frozen_mod_%0d", j), mod_a, 7);
      check($sformatf("a_frozen_dir_%0d", j), dir_a, 1);
    end
    enable_a = 1'b1;
    tick();
    check("a_resume_mod", mod_a, 8);

    // Degenerate ranges 9/9 and 9/4.
    low_a = 4'd9; high_a = 4'd9;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("a_eq_mod_%0d", j), mod_a, 9);
      check($sformatf("a_eq_dir_%0d", j), dir_a, 1);
      check($sformatf("a_eq_pulse_%0d", j), {peak_a, trough_a}, 0);
    end
    high_a = 4'd4;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("a_inv_mod_%0d", j), mod_a, 9);
      check($sformatf("a_inv_dir_%0d", j), dir_a, 1);
      check($sformatf("a_inv_pulse_%0d", j), {peak_a, trough_a}, 0);
    end

    // DIV = 3 over 0..3: each value held 3 cycles, period 18 cycles.
    check("b_rst_mod", mod_b, 0);
    check("b_rst_dir", dir_b, 1);
    reset_b = 1'b0; enable_b = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      int s;
      tick();
      s = k / 3;
      e = (s <= 3) ? s : ((s <= 6) ? 6 - s : s - 6);
      check($sformatf("b_mod_%0d", k), mod_b, e);
      check($sformatf("b_peak_%0d", k), peak_b, (k == 9) ? 1 : 0);
      check($sformatf("b_trough_%0d", k), trough_b, (k == 18) ? 1 : 0);
    end
    reset_b = 1'b1;
    tick();
    check("b_midrst_mod", mod_b, 0);
    check("b_midrst_dir", dir_b, 1);
    check("b_midrst_pulse", {peak_b, trough_b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_triangle_wave
